// File: rtl/ps2_pkg.sv
// Shared frame-state encoding, PS/2 prefix bytes and the list of bytes the decoder drops.
// Latency: n/a (declarations only); backpressure: n/a.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Keyboard status replies (BAT, ACK, echo, resend, buffer errors) carry no key event.
   function automatic logic is_discard(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and the decoded key-event outputs; master is the decoder, slave its environment.
// Latency: n/a (wiring only); backpressure: none, events are toggle-signalled.
interface ps2_key_decoder_if;
   logic        ps2_clk_in;
   logic        ps2_data_in;
   logic [10:0] ps2_key;
   logic        frame_err;

   modport master (input ps2_clk_in, input ps2_data_in, output ps2_key, output frame_err);
   modport slave  (output ps2_clk_in, output ps2_data_in, input ps2_key, input frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock and emits a one-cycle strobe on its filtered fall.
// Latency: 2 sync cycles + FILTER_LEN samples; backpressure: none.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic i_clk_raw,
   input  logic i_data_raw,
   output logic o_data,
   output logic o_fall
);
   localparam int            CW       = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]    r_clk_sync;
   logic [1:0]    r_data_sync;
   logic          r_clk_filt;
   logic [CW-1:0] r_cnt;
   logic          w_clk_s;
   logic          w_change;

   assign w_clk_s  = r_clk_sync[1];
   assign w_change = (w_clk_s != r_clk_filt) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_filt  <= 1'b1;
         r_cnt       <= '0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_clk_raw};
         r_data_sync <= {r_data_sync[0], i_data_raw};
         // Any sample matching the current level restarts the run of differing samples.
         if (w_clk_s == r_clk_filt) begin
            r_cnt <= '0;
         end else if (w_change) begin
            r_clk_filt <= w_clk_s;
            r_cnt      <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   assign o_fall = w_change & ~w_clk_s;
   assign o_data = r_data_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0/E1 prefixes and emits toggle-flagged 11-bit key events.
// Latency: ps2_key/frame_err 1 cycle after the stop-bit strobe; backpressure: none, consumer edge-detects bit 10.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 18000
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   ps2_key_decoder_if.master  bus
);
   localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);

   logic         w_data;
   logic         w_strobe;
   frame_state_t r_state;
   frame_state_t w_state_nxt;
   logic [2:0]   r_bit_cnt;
   logic [7:0]   r_byte;
   logic         r_perr;
   logic [TW-1:0] r_to_cnt;
   logic         r_ext;
   logic         r_brk;
   logic [2:0]   r_skip;
   logic [10:0]  r_key;
   logic         r_frame_err;
   logic         w_accept;
   logic         w_stop_err;
   logic         w_timeout;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .i_clk_raw  (bus.ps2_clk_in),
      .i_data_raw (bus.ps2_data_in),
      .o_data     (w_data),
      .o_fall     (w_strobe)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_stop_err  = 1'b0;
      w_timeout   = 1'b0;
      if ((r_state != IDLE) && !w_strobe && (r_to_cnt == TO_LAST)) begin
         w_timeout   = 1'b1;
         w_state_nxt = IDLE;
      end else if (w_strobe) begin
         unique case (r_state)
            IDLE:    if (!w_data) w_state_nxt = DATA;
            DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
            PARITY:  w_state_nxt = STOP;
            STOP: begin
               w_state_nxt = IDLE;
               if (w_data && !r_perr) w_accept   = 1'b1;
               else                   w_stop_err = 1'b1;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_bit_cnt   <= '0;
         r_byte      <= '0;
         r_perr      <= 1'b0;
         r_to_cnt    <= '0;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_skip      <= '0;
         r_key       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         if ((r_state == IDLE) || w_strobe || w_timeout) r_to_cnt <= '0;
         else                                             r_to_cnt <= r_to_cnt + TO_ONE;

         if (w_timeout) begin
            r_bit_cnt <= '0;
         end else if (w_strobe) begin
            unique case (r_state)
               IDLE: begin
                  r_bit_cnt <= '0;
                  r_perr    <= 1'b0;
               end
               DATA: begin
                  r_byte    <= {w_data, r_byte[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               PARITY:  r_perr <= ~(^{r_byte, w_data});
               default: ;
            endcase
         end

         r_frame_err <= w_stop_err | w_timeout;

         // Prefix state is only meaningful within a clean run of frames.
         if (w_stop_err || w_timeout) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
         end else if (w_accept) begin
            if (r_skip != 3'd0) begin
               r_skip <= r_skip - 3'd1;
            end else if (r_byte == PS2_PAUSE) begin
               r_skip <= PAUSE_SKIP;
               r_ext  <= 1'b0;
               r_brk  <= 1'b0;
            end else if (r_byte == PS2_EXT) begin
               r_ext <= 1'b1;
            end else if (r_byte == PS2_BRK) begin
               r_brk <= 1'b1;
            end else if (is_discard(r_byte)) begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
            end else begin
               r_key <= {~r_key[10], ~r_brk, r_ext, r_byte};
               r_ext <= 1'b0;
               r_brk <= 1'b0;
            end
         end
      end
   end

   assign bus.ps2_key   = r_key;
   assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames on a fast device clock and checks key events and errors.
// Latency/backpressure: n/a.
module tb_ps2_key_decoder;
   localparam int HALF = 20;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   err_cycles = 0;
   int   err_pulses = 0;
   int   key_evts   = 0;
   logic        prev_err = 1'b0;
   logic [10:0] prev_key = '0;

   ps2_key_decoder_if bus();

   ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(18000)) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (bus.frame_err) err_cycles++;
      if (bus.frame_err && !prev_err) err_pulses++;
      if (bus.ps2_key !== prev_key) key_evts++;
      prev_err = bus.frame_err;
      prev_key = bus.ps2_key;
   end

   initial begin
      repeat (90000) @(posedge clk_sys);
      $display("FAIL watchdog: cycles=90000 limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_flip, input logic stop);
      return {stop, (~^b) ^ par_flip, b, 1'b0};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         bus.ps2_data_in = bits[i];
         tick(HALF);
         bus.ps2_clk_in = 1'b0;
         tick(HALF);
         bus.ps2_clk_in = 1'b1;
      end
      bus.ps2_data_in = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(mk_frame(b, 1'b0, 1'b1), 11);
      tick(5);
   endtask

   task automatic test_reset();
      bus.ps2_clk_in  = 1'b1;
      bus.ps2_data_in = 1'b1;
      reset_n = 1'b0;
      tick(5);
      checks++;
      if (bus.ps2_key !== 11'h000) begin failures++; $display("FAIL reset_key: got %h want 000", bus.ps2_key); end
      checks++;
      if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
      reset_n = 1'b1;
      tick(5);
   endtask

   task automatic test_make();
      int e0, k0;
      e0 = err_pulses; k0 = key_evts;
      send_byte(8'h29);
      checks++;
      if (bus.ps2_key !== 11'h629) begin failures++; $display("FAIL make_key: got %h want 629", bus.ps2_key); end
      checks++;
      if (err_pulses - e0 !== 0) begin failures++; $display("FAIL make_err: got %0d pulses want 0", err_pulses - e0); end
      checks++;
      if (key_evts - k0 !== 1) begin failures++; $display("FAIL make_evts: got %0d want 1", key_evts - k0); end
   endtask

   task automatic test_ext_break();
      int k0;
      k0 = key_evts;
      send_byte(8'hE0);
      checks++;
      if (bus.ps2_key !== 11'h629) begin failures++; $display("FAIL ext_prefix: got %h want 629", bus.ps2_key); end
      send_byte(8'hF0);
      checks++;
      if (bus.ps2_key !== 11'h629) begin failures++; $display("FAIL brk_prefix: got %h want 629", bus.ps2_key); end
      send_byte(8'h75);
      checks++;
      if (bus.ps2_key !== 11'h175) begin failures++; $display("FAIL ext_brk_key: got %h want 175", bus.ps2_key); end
      checks++;
      if (key_evts - k0 !== 1) begin failures++; $display("FAIL ext_brk_evts: got %0d want 1", key_evts - k0); end
   endtask

   task automatic test_parity_err();
      int e0, c0;
      e0 = err_pulses; c0 = err_cycles;
      send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
      tick(5);
      checks++;
      if (err_pulses - e0 !== 1) begin failures++; $display("FAIL parity_pulses: got %0d want 1", err_pulses - e0); end
      checks++;
      if (err_cycles - c0 !== 1) begin failures++; $display("FAIL parity_width: got %0d cycles want 1", err_cycles - c0); end
      checks++;
      if (bus.ps2_key !== 11'h175) begin failures++; $display("FAIL parity_key_hold: got %h want 175", bus.ps2_key); end
      send_byte(8'h1C);
      checks++;
      if (bus.ps2_key !== 11'h61C) begin failures++; $display("FAIL parity_recover: got %h want 61c", bus.ps2_key); end
   endtask

   task automatic test_stop_err();
      int e0;
      e0 = err_pulses;
      send_bits(mk_frame(8'h29, 1'b0, 1'b0), 11);
      tick(5);
      checks++;
      if (err_pulses - e0 !== 1) begin failures++; $display("FAIL stop_pulses: got %0d want 1", err_pulses - e0); end
      checks++;
      if (bus.ps2_key !== 11'h61C) begin failures++; $display("FAIL stop_key_hold: got %h want 61c", bus.ps2_key); end
   endtask

   task automatic test_discard();
      int k0;
      k0 = key_evts;
      send_byte(8'hE0);
      send_byte(8'hAA);
      checks++;
      if (bus.ps2_key !== 11'h61C) begin failures++; $display("FAIL discard_hold: got %h want 61c", bus.ps2_key); end
      send_byte(8'h75);
      checks++;
      if (bus.ps2_key !== 11'h275) begin failures++; $display("FAIL discard_clears_ext: got %h want 275", bus.ps2_key); end
      checks++;
      if (key_evts - k0 !== 1) begin failures++; $display("FAIL discard_evts: got %0d want 1", key_evts - k0); end
   endtask

   task automatic test_back_to_back();
      int k0;
      k0 = key_evts;
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
      send_bits(mk_frame(8'h32, 1'b0, 1'b1), 11);
      tick(5);
      checks++;
      if (bus.ps2_key !== 11'h232) begin failures++; $display("FAIL b2b_key: got %h want 232", bus.ps2_key); end
      checks++;
      if (key_evts - k0 !== 2) begin failures++; $display("FAIL b2b_evts: got %0d want 2", key_evts - k0); end
   endtask

   task automatic test_timeout();
      int e0, c0;
      e0 = err_pulses; c0 = err_cycles;
      send_bits(mk_frame(8'h55, 1'b0, 1'b1), 5);
      tick(17880);
      checks++;
      if (err_pulses - e0 !== 0) begin failures++; $display("FAIL timeout_early: got %0d pulses want 0", err_pulses - e0); end
      tick(300);
      checks++;
      if (err_pulses - e0 !== 1) begin failures++; $display("FAIL timeout_pulse: got %0d pulses want 1", err_pulses - e0); end
      checks++;
      if (err_cycles - c0 !== 1) begin failures++; $display("FAIL timeout_width: got %0d cycles want 1", err_cycles - c0); end
      send_byte(8'h16);
      checks++;
      if (bus.ps2_key !== 11'h616) begin failures++; $display("FAIL timeout_recover: got %h want 616", bus.ps2_key); end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8];
      int e0, k0;
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      e0 = err_pulses; k0 = key_evts;
      for (int i = 0; i < 8; i++) send_byte(seq[i]);
      checks++;
      if (key_evts - k0 !== 0) begin failures++; $display("FAIL pause_evts: got %0d want 0", key_evts - k0); end
      checks++;
      if (err_pulses - e0 !== 0) begin failures++; $display("FAIL pause_err: got %0d want 0", err_pulses - e0); end
      send_byte(8'h16);
      checks++;
      if (bus.ps2_key !== 11'h216) begin failures++; $display("FAIL pause_after: got %h want 216", bus.ps2_key); end
   endtask

   task automatic test_glitch();
      int e0, k0;
      e0 = err_pulses; k0 = key_evts;
      bus.ps2_data_in = 1'b0;
      tick(5);
      bus.ps2_clk_in = 1'b0;
      tick(3);
      bus.ps2_clk_in = 1'b1;
      tick(40);
      bus.ps2_data_in = 1'b1;
      checks++;
      if ((err_pulses - e0 !== 0) || (key_evts - k0 !== 0)) begin
         failures++; $display("FAIL glitch_quiet: got err=%0d evts=%0d want 0 0", err_pulses - e0, key_evts - k0);
      end
      send_byte(8'h29);
      checks++;
      if (bus.ps2_key !== 11'h629) begin failures++; $display("FAIL glitch_next: got %h want 629", bus.ps2_key); end
   endtask

   task automatic test_reset_mid();
      send_byte(8'hE0);
      send_bits(mk_frame(8'h75, 1'b0, 1'b1), 4);
      reset_n = 1'b0;
      tick(3);
      checks++;
      if ((bus.ps2_key !== 11'h000) || (bus.frame_err !== 1'b0)) begin
         failures++; $display("FAIL midreset_out: got key=%h err=%b want 000 0", bus.ps2_key, bus.frame_err);
      end
      reset_n = 1'b1;
      tick(5);
      send_byte(8'h75);
      checks++;
      if (bus.ps2_key !== 11'h675) begin failures++; $display("FAIL midreset_next: got %h want 675", bus.ps2_key); end
   endtask

   initial begin
      test_reset();
      test_make();
      test_ext_break();
      test_parity_err();
      test_stop_err();
      test_discard();
      test_back_to_back();
      test_timeout();
      test_pause();
      test_glitch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
